// File: rtl/rv_dmem_ctrl.sv
// Data-memory controller: byte-writable word SRAM behind a fixed-latency read pipe and a response FIFO.
// Latency: a read enters the response FIFO RD_LAT edges after its accept edge; rsp_vld rises one cycle later.
// Backpressure: registered credit check, req_ready = (reads in pipe + FIFO occupancy) < RSP_DEPTH, for all request types.
//
// Ports:
//   sclk, rstn                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (transfer when both high at posedge sclk)
//   req_addr, req_data, req_type,   byte address, store data, type (01 write, 10 read),
//   req_len, req_mask, req_cid      length (0 = 4 bytes), byte enables, request tag
//   rsp_vld/rsp_ready               response handshake (pop when both high)
//   rsp_cid, rsp_data               response tag and load data
//   err_pulse                       one-cycle pulse after each accepted illegal request
//   stat_rd_cnt, stat_wr_cnt        legal read/write counters, present only with RV_DMEM_STATS_EN defined
//
// Optional feature macro: RV_DMEM_STATS_EN (adds the saturating statistics counters and their ports).

// ---------------------------------------------------------------------------
// Generic synchronous FIFO used for the response queue.
// Latency: data written at an edge is visible on o_dat after that edge.
// Backpressure: none internally; the producer must guarantee space (an assertion flags overflow).
//
// Ports: i_push/i_push_dat write side, i_pop/o_vld/o_dat read side (first-word fall-through).
// ---------------------------------------------------------------------------
module rv_dmem_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic         sclk,
    input  logic         rstn,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [CW-1:0]           r_cnt;
    logic                    w_pop;

    assign w_pop = i_pop && (r_cnt != '0);
    assign o_vld = (r_cnt != '0);
    assign o_dat = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_push_dat;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
        end
    end

    // A push into a full FIFO without a simultaneous pop would lose data.
    a_no_overflow: assert property (@(posedge sclk) disable iff (!rstn)
        !(i_push && (r_cnt == CW'(DEPTH)) && !w_pop));

endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module rv_dmem_ctrl #(
    parameter int AW        = 10,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic        sclk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_type,
    input  logic [3:0]  req_len,
    input  logic [3:0]  req_mask,
    input  logic [4:0]  req_cid,
    output logic        rsp_vld,
    input  logic        rsp_ready,
    output logic [4:0]  rsp_cid,
    output logic [31:0] rsp_data,
    output logic        err_pulse
`ifdef RV_DMEM_STATS_EN
    ,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt
`endif
);
    localparam int DEPTH_W = 1 << AW;
    localparam int CW      = $clog2(RSP_DEPTH + 1);

    localparam logic [1:0] TYPE_WR = 2'b01;
    localparam logic [1:0] TYPE_RD = 2'b10;

    typedef struct packed {
        logic [4:0]  cid;
        logic [31:0] dat;
    } rsp_t;

    // Request decode
    logic          w_acc;
    logic          w_pop;
    logic          w_legal;
    logic          w_rd_acc;
    logic          w_wr_en;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;
    logic          w_unused;

    // Credit and status registers
    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_credit_nxt;
    logic          r_req_ready;
    logic          r_err;

    // Read pipeline
    logic [RD_LAT-1:0]       r_pipe_vld;
    rsp_t [RD_LAT-1:0]       r_pipe;
    logic                    w_push;
    rsp_t                    w_push_dat;
    rsp_t                    w_fifo_dat;
    logic                    w_fifo_vld;

    assign w_acc    = req_valid && r_req_ready;
    assign w_pop    = w_fifo_vld && rsp_ready;
    assign w_legal  = ((req_type == TYPE_WR) || (req_type == TYPE_RD)) &&
                      (req_len == 4'h0) && (req_addr[1:0] == 2'b00);
    // Every read-typed request, legal or not, owes the consumer a response.
    assign w_rd_acc = w_acc && (req_type == TYPE_RD);
    assign w_wr_en  = w_acc && w_legal && (req_type == TYPE_WR);
    // Upper address bits alias onto the same words.
    assign w_idx    = req_addr[AW+1:2];
    assign w_unused = ^req_addr[31:AW+2];

    // -----------------------------------------------------------------------
    // Data SRAM, one byte-wide array per lane so each lane has its own write enable.
    // Contents are deliberately not reset.
    // -----------------------------------------------------------------------
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] r_lane [DEPTH_W];

        always_ff @(posedge sclk) begin
            if (w_wr_en && req_mask[b]) begin
                r_lane[w_idx] <= req_data[8*b +: 8];
            end
        end

        assign w_rd_word[8*b +: 8] = r_lane[w_idx];
    end

    // -----------------------------------------------------------------------
    // Read pipeline: the word is sampled at the accept edge, then carried with
    // its tag for RD_LAT-1 further stages. Illegal reads carry zero data.
    // -----------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_pipe_vld <= '0;
            r_pipe     <= '0;
        end else begin
            r_pipe_vld[0]  <= w_rd_acc;
            r_pipe[0].cid  <= req_cid;
            r_pipe[0].dat  <= w_legal ? w_rd_word : 32'h0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe[i]     <= r_pipe[i-1];
            end
        end
    end

    assign w_push     = r_pipe_vld[RD_LAT-1];
    assign w_push_dat = r_pipe[RD_LAT-1];

    rv_dmem_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .sclk       (sclk),
        .rstn       (rstn),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_vld      (w_fifo_vld),
        .o_dat      (w_fifo_dat)
    );

    assign rsp_vld  = w_fifo_vld;
    assign rsp_cid  = w_fifo_dat.cid;
    assign rsp_data = w_fifo_dat.dat;

    // -----------------------------------------------------------------------
    // Credits: reads in the pipe plus FIFO occupancy. Ready is computed from the
    // post-edge count so the FIFO can never be oversubscribed, and it gates
    // writes too so a write cannot slip past a stalled read.
    // -----------------------------------------------------------------------
    assign w_credit_nxt = r_credit + CW'(w_rd_acc) - CW'(w_pop);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_credit    <= '0;
            r_req_ready <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_credit    <= w_credit_nxt;
            r_req_ready <= (w_credit_nxt < CW'(RSP_DEPTH));
            r_err       <= w_acc && !w_legal;
        end
    end

    assign req_ready = r_req_ready;
    assign err_pulse = r_err;

    a_credit_bound: assert property (@(posedge sclk) disable iff (!rstn)
        r_credit <= CW'(RSP_DEPTH));

`ifdef RV_DMEM_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating counters of accepted legal reads and writes.
    // -----------------------------------------------------------------------
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_wr;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            if (w_rd_acc && w_legal && (r_stat_rd != 16'hFFFF)) begin
                r_stat_rd <= r_stat_rd + 16'd1;
            end
            if (w_wr_en && (r_stat_wr != 16'hFFFF)) begin
                r_stat_wr <= r_stat_wr + 16'd1;
            end
        end
    end

    assign stat_rd_cnt = r_stat_rd;
    assign stat_wr_cnt = r_stat_wr;
`endif

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Self-checking bench for rv_dmem_ctrl: directed scenarios followed by random traffic.
// Reference: byte-level memory array plus an in-order queue of expected responses with visibility times.
// Inputs driven 1 time unit after posedge sclk, outputs sampled at negedge sclk.
module tb_rv_dmem_ctrl;
    localparam int AW     = 10;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic        sclk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_type;
    logic [3:0]  req_len;
    logic [3:0]  req_mask;
    logic [4:0]  req_cid;
    logic        rsp_vld;
    logic        rsp_ready;
    logic [4:0]  rsp_cid;
    logic [31:0] rsp_data;
    logic        err_pulse;
`ifdef RV_DMEM_STATS_EN
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
`endif

    rv_dmem_ctrl #(
        .AW        (AW),
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_type  (req_type),
        .req_len   (req_len),
        .req_mask  (req_mask),
        .req_cid   (req_cid),
        .rsp_vld   (rsp_vld),
        .rsp_ready (rsp_ready),
        .rsp_cid   (rsp_cid),
        .rsp_data  (rsp_data),
        .err_pulse (err_pulse)
`ifdef RV_DMEM_STATS_EN
        ,
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt)
`endif
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Reference model state
    typedef struct {
        logic [4:0]  cid;
        logic [31:0] dat;
        int          avail;   // first cycle in which this response may be visible
    } exp_t;

    exp_t        q[$];
    logic [4:0]  popped[$];
    logic [31:0] mdl [0:(1<<AW)-1];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_cnt  = 0;
    int          m_rd     = 0;
    int          m_wr     = 0;
    bit          m_err    = 1'b0;
    bit          acc_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, then account for the
    // handshakes that the coming edge will perform.
    task automatic step();
        logic          lg;
        logic [AW-1:0] idx;
        logic          exp_vld;
        exp_t          e;
        @(negedge sclk);
        chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
        chk("err_pulse", 32'(err_pulse), 32'(m_err));
        exp_vld = 1'b0;
        if (q.size() > 0) exp_vld = (q[0].avail <= cyc);
        chk("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
        if (rsp_vld && rsp_ready) begin
            popped.push_back(rsp_cid);
            n_checks++;
            assert (q.size() > 0) else begin
                n_fail++;
                $error("FAIL rsp_unexpected: observed cid 0x%0h expected no response", rsp_cid);
            end
            if (q.size() > 0) begin
                chk("rsp_cid", 32'(rsp_cid), 32'(q[0].cid));
                chk("rsp_data", rsp_data, q[0].dat);
                void'(q.pop_front());
            end
        end
        acc_last = req_valid && req_ready;
        m_err    = 1'b0;
        if (acc_last) begin
            acc_cnt++;
            lg  = ((req_type == 2'b01) || (req_type == 2'b10)) && (req_len == 4'h0) && (req_addr[1:0] == 2'b00);
            idx = req_addr[AW+1:2];
            m_err = !lg;
            if (lg && req_type == 2'b01) begin
                m_wr++;
                for (int b = 0; b < 4; b++)
                    if (req_mask[b]) mdl[idx][8*b +: 8] = req_data[8*b +: 8];
            end
            if (req_type == 2'b10) begin
                if (lg) m_rd++;
                e.cid   = req_cid;
                e.dat   = lg ? mdl[idx] : 32'h0;
                e.avail = cyc + RD_LAT + 1;
                q.push_back(e);
            end
        end
        @(posedge sclk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_acc();
        for (int n = 0; n < 100; n++) begin
            step();
            if (acc_last) break;
        end
        n_checks++;
        assert (acc_last) else begin
            n_fail++;
            $error("FAIL accept_timeout: observed no accept expected accept within 100 cycles");
        end
        req_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [4:0] c, input logic [3:0] l);
        req_type  = t;
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
        req_cid   = c;
        req_len   = l;
        req_valid = 1'b1;
        wait_acc();
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (q.size() == 0) break;
            step();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_cid", 32'(rsp_cid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        q.delete();
        m_err = 1'b0;
        m_rd  = 0;
        m_wr  = 0;
        repeat (2) begin
            @(posedge sclk);
            cyc++;
        end
        #1;
        rstn = 1'b1;
        chk("rel_ready_low", 32'(req_ready), 32'd0);
        @(posedge sclk);
        #1;
        cyc++;
        chk("rel_ready_high", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int r;
        int word;

        rstn      = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_type  = '0;
        req_len   = '0;
        req_mask  = '0;
        req_cid   = '0;
        rsp_ready = 1'b1;
        #3;
        do_reset();

        // Fill the 64 words used below, with random aliased upper address bits.
        for (int w = 0; w < 64; w++)
            send(2'b01, ($urandom() & 32'hFFFF_F000) | 32'(w << 2), $urandom(), 4'hF, 5'd0, 4'h0);

        // Write then read back; response visible RD_LAT+1 cycles after accept.
        send(2'b01, 32'h10, 32'hA5A5_1234, 4'hF, 5'd0, 4'h0);
        send(2'b10, 32'h10, 32'h0, 4'h0, 5'd5, 4'h0);
        idle(RD_LAT);
        chk("t1_vld", 32'(rsp_vld), 32'd1);
        chk("t1_data", rsp_data, 32'hA5A5_1234);
        chk("t1_cid", 32'(rsp_cid), 32'd5);
        drain();

        // Byte masks.
        send(2'b01, 32'h20, 32'hFFFF_FFFF, 4'hF, 5'd0, 4'h0);
        send(2'b01, 32'h20, 32'h0000_0000, 4'b0101, 5'd0, 4'h0);
        send(2'b10, 32'h20, 32'h0, 4'h0, 5'd9, 4'h0);
        idle(RD_LAT);
        chk("t2_data", rsp_data, 32'hFF00_FF00);
        drain();

        // Credit backpressure with the consumer stalled.
        rsp_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 1; i <= 4; i++) send(2'b10, 32'(i << 2), 32'h0, 4'h0, 5'(i), 4'h0);
        req_type  = 2'b10;
        req_addr  = 32'h14;
        req_cid   = 5'd5;
        req_len   = 4'h0;
        req_valid = 1'b1;
        repeat (6) step();
        chk("bp_accepted", 32'(acc_cnt - a0), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        popped.delete();
        rsp_ready = 1'b1;
        wait_acc();
        send(2'b10, 32'h18, 32'h0, 4'h0, 5'd6, 4'h0);
        drain();
        chk("bp_pop_count", 32'(popped.size()), 32'd6);
        for (int i = 0; i < 6 && i < popped.size(); i++) chk("bp_order", 32'(popped[i]), 32'(i + 1));

        // Misaligned read and illegal type.
        send(2'b10, 32'h13, 32'h0, 4'h0, 5'd7, 4'h0);
        chk("ill_err_hi", 32'(err_pulse), 32'd1);
        idle(1);
        chk("ill_err_lo", 32'(err_pulse), 32'd0);
        idle(1);
        chk("ill_vld", 32'(rsp_vld), 32'd1);
        chk("ill_data", rsp_data, 32'h0);
        chk("ill_cid", 32'(rsp_cid), 32'd7);
        drain();
        send(2'b10, 32'h10, 32'h0, 4'h0, 5'd8, 4'h0);
        idle(RD_LAT);
        chk("ill_mem_kept", rsp_data, 32'hA5A5_1234);
        drain();
        send(2'b11, 32'h20, 32'hDEAD_BEEF, 4'hF, 5'd9, 4'h0);
        chk("t11_err", 32'(err_pulse), 32'd1);
        idle(6);
        chk("t11_no_rsp", 32'(rsp_vld), 32'd0);

        // Reset with reads in flight.
        rsp_ready = 1'b0;
        send(2'b10, 32'h10, 32'h0, 4'h0, 5'd10, 4'h0);
        send(2'b10, 32'h20, 32'h0, 4'h0, 5'd11, 4'h0);
        send(2'b10, 32'h40, 32'h0, 4'h0, 5'd12, 4'h0);
        idle(RD_LAT);
        chk("mf_vld_before", 32'(rsp_vld), 32'd1);
        do_reset();
        rsp_ready = 1'b1;
        idle(8);
        chk("mf_no_stale", 32'(rsp_vld), 32'd0);
        send(2'b10, 32'h20, 32'h0, 4'h0, 5'd13, 4'h0);
        idle(RD_LAT);
        chk("mf_data_kept", rsp_data, 32'hFF00_FF00);
        chk("mf_cid", 32'(rsp_cid), 32'd13);
        drain();

        // Random traffic against the model; requests are held until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!req_valid && $urandom_range(0, 9) < 8) begin
                r    = $urandom_range(0, 19);
                word = $urandom_range(0, 63);
                req_addr = ($urandom() & 32'hFFFF_F000) | 32'(word << 2);
                req_data = $urandom();
                req_mask = 4'($urandom());
                req_cid  = 5'($urandom());
                req_len  = 4'h0;
                if (r < 9) req_type = 2'b01;
                else if (r < 18) req_type = 2'b10;
                else if (r == 18) req_type = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                else begin
                    req_type = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
                    if ($urandom_range(0, 1) != 0) req_len = 4'($urandom_range(1, 15));
                    else req_addr[1:0] = 2'($urandom_range(1, 3));
                end
                req_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
            if (acc_last) req_valid = 1'b0;
        end
        drain();
`ifdef RV_DMEM_STATS_EN
        chk("stat_rd_rand", 32'(stat_rd_cnt), 32'(m_rd));
        chk("stat_wr_rand", 32'(stat_wr_cnt), 32'(m_wr));
`endif

        // Statistics: 3 legal writes, 2 legal reads, 1 illegal.
        do_reset();
        send(2'b01, 32'h100, 32'h1, 4'hF, 5'd0, 4'h0);
        send(2'b01, 32'h104, 32'h2, 4'hF, 5'd0, 4'h0);
        send(2'b01, 32'h108, 32'h3, 4'h3, 5'd0, 4'h0);
        send(2'b10, 32'h100, 32'h0, 4'h0, 5'd20, 4'h0);
        send(2'b10, 32'h104, 32'h0, 4'h0, 5'd21, 4'h0);
        send(2'b00, 32'h100, 32'h0, 4'hF, 5'd22, 4'h0);
        drain();
`ifdef RV_DMEM_STATS_EN
        chk("stat_wr", 32'(stat_wr_cnt), 32'd3);
        chk("stat_rd", 32'(stat_rd_cnt), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_dmem_ctrl.md
Name: rv_dmem_ctrl

Overview:
Data-memory controller on the load/store side of the register file. Consumes the register file's memory request channel (regf2mem_req_*) and produces its response channel (mem2regf_rsp_*). Holds a word-organised, byte-writable data SRAM with a fixed-latency read pipeline and a credit-protected response FIFO, so the register file can apply backpressure without losing load data.

Parameters:
AW, 10, log2 of memory depth in 32-bit words (memory spans 4*2^AW bytes)
RD_LAT, 2, read pipeline latency in cycles from accept to FIFO write; legal range 1..4
RSP_DEPTH, 4, response FIFO entries; power of 2, >= 2

Ports:
sclk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
req_valid  input  1  request valid
req_ready  output  1  request ready; a transfer occurs when req_valid && req_ready at posedge sclk
req_addr  input  32  byte address
req_data  input  32  store data
req_type  input  2  2'b01 write, 2'b10 read, others illegal
req_len  input  4  4'h0 = 4 bytes; other values illegal
req_mask  input  4  byte enables for writes; bit i -> req_data[8i+7:8i]
req_cid  input  5  request tag (destination register id), returned on the response
rsp_vld  output  1  response valid
rsp_ready  input  1  consumer ready; pop when rsp_vld && rsp_ready
rsp_cid  output  5  tag of the current response
rsp_data  output  32  read data
err_pulse  output  1  one-cycle pulse for each accepted illegal request

Behaviour:
- Reset, asynchronous on rstn low: req_ready=0, rsp_vld=0, rsp_cid=0, rsp_data=0, err_pulse=0. Read pipeline valids cleared, FIFO pointers and credit counter zeroed. Memory contents are not reset.
- Reset mid-operation: in-flight reads and queued responses are discarded. req_ready rises in the first cycle after rstn deasserts.
- Word index = req_addr[AW+1:2]. Upper address bits are ignored (the address aliases).
- Credits: outstanding = reads in pipeline + FIFO occupancy.
  - req_ready = (outstanding < RSP_DEPTH), registered.
  - req_ready applies to every request type, so writes never overtake blocked reads.
  - A pop and an accept in the same cycle leave outstanding unchanged.
- Write, legal: the masked bytes are committed at the accept edge. No response. mask=4'b0000 is legal and a no-op.
- Read, legal: the SRAM word is captured at the accept edge and shifted through RD_LAT stages with cid. It enters the FIFO at edge accept+RD_LAT.
  - With the FIFO empty and rsp_ready=1, rsp_vld is high in the cycle after edge accept+RD_LAT.
  - A read accepted the cycle after a write to the same word returns the new data.
- Illegal request: req_type not in {01,10}, req_len!=0, or req_addr[1:0]!=0.
  - Accepted normally (consumes a credit only if req_type==2'b10).
  - No memory effect. err_pulse=1 in the cycle after accept.
  - An illegal read still returns a response, with rsp_data=32'h0 and its cid, so the consumer never hangs.
- FIFO:
  - Responses are returned strictly in accept order.
  - rsp_cid and rsp_data stay stable while rsp_vld && !rsp_ready.
  - Overflow is impossible by construction. An assertion flags a write to a full FIFO.
  - Pointers wrap modulo RSP_DEPTH.
- Back-to-back: one request per cycle sustained while rsp_ready=1 (full throughput).

Optional Feature:
Macro RV_DMEM_STATS_EN.
- Defined: adds outputs stat_rd_cnt[15:0] and stat_wr_cnt[15:0], counting accepted legal reads and legal writes. Both reset to 0, saturate at 16'hFFFF, and are readable at all times.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Write addr 0x10, data 0xA5A5_1234, mask 4'hF; then read addr 0x10 with cid 5 -> rsp_vld RD_LAT+1 cycles after the read accept, rsp_data=0xA5A5_1234, rsp_cid=5.
- Write 0xFFFF_FFFF to 0x20 with mask 4'hF; then write 0x0000_0000 with mask 4'b0101; read 0x20 -> 0xFF00_FF00.
- Hold rsp_ready=0 and issue reads cid 1..6 back-to-back -> exactly 4 accepted, then req_ready=0. Release rsp_ready -> responses return with cids 1,2,3,4 in order, then 5,6 are accepted.
- Read addr 0x13 (misaligned) with cid 7 -> err_pulse for one cycle, response with rsp_data=0, cid 7, memory unchanged. req_type=2'b11 -> err_pulse, no response.
- Issue 3 reads, assert rstn=0 mid-flight -> rsp_vld=0 and req_ready=0 immediately. After release, no stale responses appear and previously written data is still readable.
- With RV_DMEM_STATS_EN defined: 3 legal writes, 2 legal reads, 1 illegal -> stat_wr_cnt=3, stat_rd_cnt=2.
